// File: rtl/di2c_trigger_rx_gen.sv
// DI2C trigger receiver: filtered SCL/SDA frame decoder with CRC-16/KERMIT check,
// sub-system ID filtering and a shared busy line with a minimum hold time.
module di2c_trigger_rx_gen #(
  parameter int unsigned SERIAL_BYTES   = 4,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned TRIG_PULSE     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  OWN_ID         = 8'hFF,
  parameter int unsigned BUSY_MIN       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      busy_clear,
  output logic                      trigger,
  output logic [7:0]                sub_system_id,
  output logic [7:0]                trigger_type,
  output logic [8*SERIAL_BYTES-1:0] trigger_serial,
  output logic                      crc_status,
  output logic                      id_match,
  output logic                      end_flag,
  output logic                      frame_error,
  output logic                      timeout_error,
  output logic                      overrun,
  input  logic                      ro_sda,
  input  logic                      ro_scl,
  input  logic                      ro_busy,
  output logic                      ren_sda,
  output logic                      de_sda,
  output logic                      ren_scl,
  output logic                      de_scl,
  output logic                      di_sda,
  output logic                      di_scl,
  output logic                      ren_busy,
  output logic                      de_busy,
  output logic                      di_busy
);
  localparam int unsigned SW        = 8 * SERIAL_BYTES;
  localparam logic [3:0]  CRC_HI    = 4'(SERIAL_BYTES + 2);
  localparam logic [3:0]  LAST_BYTE = 4'(SERIAL_BYTES + 3);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  logic w_unused_ro_busy;
  assign w_unused_ro_busy = ro_busy;

  assign ren_sda  = 1'b0;
  assign de_sda   = 1'b0;
  assign ren_scl  = 1'b0;
  assign de_scl   = 1'b0;
  assign di_sda   = 1'bz;
  assign di_scl   = 1'bz;
  assign ren_busy = 1'b1;
  assign de_busy  = 1'b1;

  // Bit 1 = SCL, bit 0 = SDA; each gets a 2-FF synchroniser and a run-length filter.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  assign w_raw = {ro_scl, ro_sda};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       r_s1;
      logic       r_s2;
      logic       r_f;
      logic [3:0] r_cnt;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_s1  <= 1'b1;
          r_s2  <= 1'b1;
          r_f   <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_f) begin
            r_cnt <= '0;
          end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
            r_f   <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      end
      assign w_filt[gi] = r_f;
    end
  endgenerate

  logic w_scl, w_sda;
  assign w_scl = w_filt[1];
  assign w_sda = w_filt[0];

  logic r_scl_p, r_sda_p;
  logic r_ev_rise, r_ev_start, r_ev_stop, r_ev_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
      r_ev_rise  <= 1'b0;
      r_ev_start <= 1'b0;
      r_ev_stop  <= 1'b0;
      r_ev_bit   <= 1'b1;
    end else begin
      r_scl_p    <= w_scl;
      r_sda_p    <= w_sda;
      r_ev_rise  <= w_scl & ~r_scl_p;
      r_ev_start <= w_scl & r_scl_p & r_sda_p & ~w_sda;
      r_ev_stop  <= w_scl & r_scl_p & ~r_sda_p & w_sda;
      r_ev_bit   <= w_sda;
    end
  end

  logic r_clr1, r_clr2, r_clr3;
  logic w_clr_rise;
  assign w_clr_rise = r_clr2 & ~r_clr3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clr1 <= 1'b1;
      r_clr2 <= 1'b1;
      r_clr3 <= 1'b1;
    end else begin
      r_clr1 <= busy_clear;
      r_clr2 <= r_clr1;
      r_clr3 <= r_clr2;
    end
  end

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
    end
    return x;
  endfunction

  state_t          r_state;
  logic [3:0]      r_bit_cnt, r_byte_cnt;
  logic [6:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_byte_valid;
  logic [15:0]     r_crc, r_rx_crc;
  logic [7:0]      r_sh_id, r_sh_type;
  logic [SW-1:0]   r_sh_serial;
  logic [31:0]     r_to_cnt;
  logic [7:0]      r_trig_cnt;
  logic            r_busy, r_req;
  logic [31:0]     r_busy_cnt;
  logic            r_trigger, r_crc_ok, r_id_ok, r_end, r_ferr, r_terr, r_ovr;
  logic [7:0]      r_id, r_type;
  logic [SW-1:0]   r_serial;

  logic [7:0] w_byte;
  logic       w_trig_set, w_to_hit, w_busy_min_ok;
  assign w_byte        = {r_shift, r_ev_bit};
  assign w_trig_set    = (r_state == S_IDLE) && r_ev_start && !r_busy;
  assign w_to_hit      = (TIMEOUT_CYCLES != 0) && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_busy_min_ok = ({1'b0, r_busy_cnt} + 33'd1) >= 33'(BUSY_MIN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_crc        <= '0;
      r_rx_crc     <= '0;
      r_sh_id      <= '0;
      r_sh_type    <= '0;
      r_sh_serial  <= '0;
      r_to_cnt     <= '0;
      r_trig_cnt   <= '0;
      r_busy       <= 1'b0;
      r_req        <= 1'b0;
      r_busy_cnt   <= '0;
      r_trigger    <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_id_ok      <= 1'b0;
      r_end        <= 1'b0;
      r_ferr       <= 1'b0;
      r_terr       <= 1'b0;
      r_ovr        <= 1'b0;
      r_id         <= '0;
      r_type       <= '0;
      r_serial     <= '0;
    end else begin
      r_end        <= 1'b0;
      r_ferr       <= 1'b0;
      r_terr       <= 1'b0;
      r_ovr        <= 1'b0;
      r_byte_valid <= 1'b0;

      if (w_trig_set) begin
        r_trigger  <= 1'b1;
        r_trig_cnt <= 8'(TRIG_PULSE - 1);
      end else if (r_trig_cnt != 8'd0) begin
        r_trig_cnt <= r_trig_cnt - 8'd1;
      end else begin
        r_trigger <= 1'b0;
      end

      // A set in the same cycle as a release request drops the request.
      if (w_trig_set) begin
        r_busy     <= 1'b1;
        r_busy_cnt <= '0;
        r_req      <= 1'b0;
      end else if (r_busy) begin
        if (r_busy_cnt != 32'hFFFF_FFFF) r_busy_cnt <= r_busy_cnt + 32'd1;
        if ((w_clr_rise || r_req) && w_busy_min_ok) begin
          r_busy <= 1'b0;
          r_req  <= 1'b0;
        end else if (w_clr_rise) begin
          r_req <= 1'b1;
        end
      end else begin
        r_req <= 1'b0;
      end

      if (r_byte_valid && (r_byte_cnt < CRC_HI)) r_crc <= crc_byte(r_crc, r_byte);

      case (r_state)
        S_IDLE: begin
          if (r_ev_start) begin
            r_ovr      <= r_busy;
            r_state    <= S_RECV;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_crc      <= '0;
            r_to_cnt   <= '0;
          end
        end
        S_RECV: begin
          if (r_ev_start) begin
            r_ferr     <= 1'b1;
            r_end      <= 1'b1;
            r_crc_ok   <= 1'b0;
            r_id_ok    <= 1'b0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_crc      <= '0;
            r_to_cnt   <= '0;
          end else if (r_ev_stop) begin
            r_ferr   <= 1'b1;
            r_end    <= 1'b1;
            r_crc_ok <= 1'b0;
            r_id_ok  <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_to_hit && !r_ev_rise) begin
            r_terr   <= 1'b1;
            r_end    <= 1'b1;
            r_crc_ok <= 1'b0;
            r_id_ok  <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_ev_rise) begin
            r_to_cnt <= '0;
            if (r_bit_cnt == 4'd8) begin
              r_bit_cnt <= '0;
              if (r_byte_cnt == LAST_BYTE) r_state <= S_CHECK;
              else r_byte_cnt <= r_byte_cnt + 4'd1;
            end else begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_byte       <= w_byte;
                r_byte_valid <= 1'b1;
                if (r_byte_cnt == 4'd0) r_sh_id <= w_byte;
                else if (r_byte_cnt == 4'd1) r_sh_type <= w_byte;
                else if (r_byte_cnt < CRC_HI) r_sh_serial <= (r_sh_serial << 8) | SW'(w_byte);
                else if (r_byte_cnt == CRC_HI) r_rx_crc[15:8] <= w_byte;
                else r_rx_crc[7:0] <= w_byte;
              end
            end
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          r_id     <= r_sh_id;
          r_type   <= r_sh_type;
          r_serial <= r_sh_serial;
          r_crc_ok <= (r_crc == r_rx_crc);
          r_id_ok  <= (OWN_ID == 8'hFF) || (r_sh_id == OWN_ID);
          r_end    <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign trigger        = r_trigger;
  assign sub_system_id  = r_id;
  assign trigger_type   = r_type;
  assign trigger_serial = r_serial;
  assign crc_status     = r_crc_ok;
  assign id_match       = r_id_ok;
  assign end_flag       = r_end;
  assign frame_error    = r_ferr;
  assign timeout_error  = r_terr;
  assign overrun        = r_ovr;
  assign di_busy        = r_busy;

endmodule

// File: tb/tb_di2c_trigger_rx_gen.sv
// Bench for di2c_trigger_rx_gen: table of frames on two configurations plus
// hand sequences for aborts, busy release, timeout, glitch and reset.
module tb_di2c_trigger_rx_gen;
  localparam int HP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, busy_clear, scl, sda, sel;
  logic scl_a, sda_a, scl_b, sda_b;
  assign scl_a = sel ? 1'b1 : scl;
  assign sda_a = sel ? 1'b1 : sda;
  assign scl_b = sel ? scl : 1'b1;
  assign sda_b = sel ? sda : 1'b1;

  logic        trig_a, crc_a, idm_a, end_a, ferr_a, terr_a, ovr_a, dbusy_a;
  logic [7:0]  sid_a, ty_a;
  logic [31:0] ser_a;
  logic        rs_a, ds_a, rc_a, dc_a, rb_a, db_a;
  wire         dis_a, dic_a;
  logic        trig_b, crc_b, idm_b, end_b, ferr_b, terr_b, ovr_b, dbusy_b;
  logic [7:0]  sid_b, ty_b;
  logic [47:0] ser_b;
  logic        rs_b, ds_b, rc_b, dc_b, rb_b, db_b;
  wire         dis_b, dic_b;

  di2c_trigger_rx_gen #(.SERIAL_BYTES(4), .FILTER_LEN(3), .TRIG_PULSE(1),
    .TIMEOUT_CYCLES(1000), .OWN_ID(8'hFF), .BUSY_MIN(50)) dut_a (
    .clk(clk), .reset(reset), .busy_clear(busy_clear), .trigger(trig_a),
    .sub_system_id(sid_a), .trigger_type(ty_a), .trigger_serial(ser_a),
    .crc_status(crc_a), .id_match(idm_a), .end_flag(end_a), .frame_error(ferr_a),
    .timeout_error(terr_a), .overrun(ovr_a), .ro_sda(sda_a), .ro_scl(scl_a),
    .ro_busy(1'b0), .ren_sda(rs_a), .de_sda(ds_a), .ren_scl(rc_a), .de_scl(dc_a),
    .di_sda(dis_a), .di_scl(dic_a), .ren_busy(rb_a), .de_busy(db_a), .di_busy(dbusy_a));

  di2c_trigger_rx_gen #(.SERIAL_BYTES(6), .FILTER_LEN(3), .TRIG_PULSE(1),
    .TIMEOUT_CYCLES(65535), .OWN_ID(8'h12), .BUSY_MIN(0)) dut_b (
    .clk(clk), .reset(reset), .busy_clear(busy_clear), .trigger(trig_b),
    .sub_system_id(sid_b), .trigger_type(ty_b), .trigger_serial(ser_b),
    .crc_status(crc_b), .id_match(idm_b), .end_flag(end_b), .frame_error(ferr_b),
    .timeout_error(terr_b), .overrun(ovr_b), .ro_sda(sda_b), .ro_scl(scl_b),
    .ro_busy(1'b0), .ren_sda(rs_b), .de_sda(ds_b), .ren_scl(rc_b), .de_scl(dc_b),
    .di_sda(dis_b), .di_scl(dic_b), .ren_busy(rb_b), .de_busy(db_b), .di_busy(dbusy_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Pulse counters per instance (0 = A, 1 = B), sampled mid-cycle.
  int c_trig[2], c_end[2], c_ferr[2], c_terr[2], c_ovr[2];
  int s_trig[2], s_end[2], s_ferr[2], s_terr[2], s_ovr[2];

  always @(negedge clk) begin
    if (trig_a) c_trig[0]++;
    if (end_a)  c_end[0]++;
    if (ferr_a) c_ferr[0]++;
    if (terr_a) c_terr[0]++;
    if (ovr_a)  c_ovr[0]++;
    if (trig_b) c_trig[1]++;
    if (end_b)  c_end[1]++;
    if (ferr_b) c_ferr[1]++;
    if (terr_b) c_terr[1]++;
    if (ovr_b)  c_ovr[1]++;
  end

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      s_trig[i] = c_trig[i];
      s_end[i]  = c_end[i];
      s_ferr[i] = c_ferr[i];
      s_terr[i] = c_terr[i];
      s_ovr[i]  = c_ovr[i];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] frm[$];

  // Bit-serial CRC-16/KERMIT over the bytes currently in frm.
  function automatic logic [15:0] kermit();
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    foreach (frm[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ frm[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic build(input logic [7:0] id, input logic [7:0] ty, input logic [63:0] ser,
                       input int nb, input logic [7:0] cx);
    logic [15:0] c;
    frm.delete();
    frm.push_back(id);
    frm.push_back(ty);
    for (int i = nb - 1; i >= 0; i--) frm.push_back(ser[8*i +: 8]);
    c = kermit();
    frm.push_back(c[15:8]);
    frm.push_back(c[7:0] ^ cx);
  endtask

  task automatic line_start();
    sda = 1'b0; tick(HP);
    scl = 1'b0; tick(HP);
  endtask

  task automatic line_byte(input logic [7:0] b);
    for (int i = 0; i < 9; i++) begin
      sda = (i < 8) ? b[7-i] : 1'b0;
      tick(HP);
      scl = 1'b1; tick(HP);
      scl = 1'b0;
    end
  endtask

  task automatic line_stop();
    sda = 1'b0; tick(HP);
    scl = 1'b1; tick(HP);
    sda = 1'b1; tick(HP);
  endtask

  task automatic send_frame();
    line_start();
    foreach (frm[k]) line_byte(frm[k]);
    line_stop();
  endtask

  typedef struct {
    bit          sel;
    logic [7:0]  id;
    logic [7:0]  ty;
    logic [63:0] ser;
    logic [7:0]  cx;
    bit          e_crc;
    bit          e_idm;
    int          e_trig;
    int          e_ovr;
  } vec_t;

  vec_t vt[5];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int j, n, hi;
    logic [63:0] ser_sel;

    vt[0] = '{1'b0, 8'h12, 8'h03, 64'h0000_0001,        8'h00, 1'b1, 1'b1, 1, 0};
    vt[1] = '{1'b0, 8'h12, 8'h03, 64'h0000_0001,        8'h01, 1'b0, 1'b1, 0, 1};
    vt[2] = '{1'b1, 8'h34, 8'h05, 64'h0000_AABB_CCDD,   8'h00, 1'b1, 1'b0, 1, 0};
    vt[3] = '{1'b1, 8'h12, 8'h07, 64'h0102_0304_0506,   8'h00, 1'b1, 1'b1, 0, 1};
    vt[4] = '{1'b0, 8'hAB, 8'hCD, 64'hDEAD_BEEF,        8'h00, 1'b1, 1'b1, 0, 1};

    reset = 1'b0; busy_clear = 1'b0; scl = 1'b1; sda = 1'b1; sel = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(10);
    @(negedge clk);
    chk("reset A trigger", trig_a, 0);
    chk("reset A busy", dbusy_a, 0);
    chk("reset A outputs", {sid_a, ty_a, ser_a, crc_a, idm_a}, 0);
    chk("reset A pulses", {end_a, ferr_a, terr_a, ovr_a}, 0);
    chk("reset B outputs", {sid_b, ty_b, ser_b, crc_b, idm_b, dbusy_b}, 0);
    chk("tie-offs", {rs_a, ds_a, rc_a, dc_a, rb_a, db_a}, 6'b000011);
    $display("reset: A id=%h busy=%0b, B id=%h busy=%0b", sid_a, dbusy_a, sid_b, dbusy_b);

    for (int k = 0; k < 5; k++) begin
      sel = vt[k].sel;
      tick(4);
      build(vt[k].id, vt[k].ty, vt[k].ser, vt[k].sel ? 6 : 4, vt[k].cx);
      snap();
      send_frame();
      tick(20);
      @(negedge clk);
      j = vt[k].sel ? 1 : 0;
      ser_sel = vt[k].sel ? 64'(ser_b) : 64'(ser_a);
      chk($sformatf("v%0d trigger pulses", k), c_trig[j] - s_trig[j], vt[k].e_trig);
      chk($sformatf("v%0d overrun", k), c_ovr[j] - s_ovr[j], vt[k].e_ovr);
      chk($sformatf("v%0d end_flag", k), c_end[j] - s_end[j], 1);
      chk($sformatf("v%0d error flags", k), (c_ferr[j] - s_ferr[j]) + (c_terr[j] - s_terr[j]), 0);
      chk($sformatf("v%0d sub_system_id", k), vt[k].sel ? sid_b : sid_a, vt[k].id);
      chk($sformatf("v%0d trigger_type", k), vt[k].sel ? ty_b : ty_a, vt[k].ty);
      chk($sformatf("v%0d trigger_serial", k), ser_sel, vt[k].ser);
      chk($sformatf("v%0d crc_status", k), vt[k].sel ? crc_b : crc_a, vt[k].e_crc);
      chk($sformatf("v%0d id_match", k), vt[k].sel ? idm_b : idm_a, vt[k].e_idm);
      chk($sformatf("v%0d busy", k), vt[k].sel ? dbusy_b : dbusy_a, 1);
      $display("vec %0d: dut=%0d id=%h type=%h serial=%h crc_status=%0b id_match=%0b",
               k, j, vt[k].id, vt[k].ty, ser_sel, vt[k].sel ? crc_b : crc_a,
               vt[k].sel ? idm_b : idm_a);
    end

    sel = 1'b0;
    tick(4);

    // Stop after three bytes: abort keeps data, clears status.
    snap();
    line_start();
    line_byte(8'h11); line_byte(8'h22); line_byte(8'h33);
    line_stop();
    tick(10);
    @(negedge clk);
    chk("stop frame_error", c_ferr[0] - s_ferr[0], 1);
    chk("stop end_flag", c_end[0] - s_end[0], 1);
    chk("stop data kept", {sid_a, ty_a, ser_a}, {8'hAB, 8'hCD, 32'hDEAD_BEEF});
    chk("stop crc_status", crc_a, 0);
    chk("stop id_match", idm_a, 0);
    $display("stop abort: frame_error pulses=%0d crc_status=%0b", c_ferr[0] - s_ferr[0], crc_a);

    // Release with BUSY_MIN long elapsed: busy falls on the third edge.
    tick(1);
    busy_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("release busy after 2 edges", dbusy_a, 1);
    @(negedge clk);
    chk("release busy after 3 edges", dbusy_a, 0);
    busy_clear = 1'b0;
    tick(10);
    $display("release: busy=%0b", dbusy_a);

    // BUSY_MIN hold: clear 10 cycles after trigger, busy must stay 50 cycles.
    build(8'h55, 8'h66, 64'h1234_5678, 4, 8'h00);
    snap();
    fork
      send_frame();
      begin
        n = 0;
        while (!trig_a && n < 200) begin @(negedge clk); n++; end
        chk("hold trigger seen", trig_a, 1);
        hi = 1;
        while (dbusy_a && hi < 500) begin
          @(negedge clk);
          if (dbusy_a) hi++;
          if (hi == 10) busy_clear = 1'b1;
          if (hi == 12) busy_clear = 1'b0;
        end
        busy_clear = 1'b0;
        chk("hold busy high cycles", hi, 50);
      end
    join
    tick(20);
    @(negedge clk);
    chk("hold trigger pulses", c_trig[0] - s_trig[0], 1);
    chk("hold frame decoded", {sid_a, ty_a, ser_a, crc_a}, {8'h55, 8'h66, 32'h1234_5678, 1'b1});
    $display("busy hold: high for %0d cycles, id=%h", hi, sid_a);

    // SCL held high after a start: timeout 1000 cycles after entering the frame.
    snap();
    sda = 1'b0;
    n = 0;
    while (!trig_a && n < 100) begin @(negedge clk); n++; end
    chk("timeout trigger seen", trig_a, 1);
    n = 0;
    while (!terr_a && n < 2000) begin @(negedge clk); n++; end
    chk("timeout cycles", n, 1000);
    sda = 1'b1;
    tick(HP);
    @(negedge clk);
    chk("timeout pulses", c_terr[0] - s_terr[0], 1);
    chk("timeout end_flag", c_end[0] - s_end[0], 1);
    chk("timeout crc_status", crc_a, 0);
    chk("timeout data kept", sid_a, 8'h55);
    $display("timeout: fired after %0d cycles", n);

    // Free busy, then a 2-cycle SDA glitch must not look like a start.
    busy_clear = 1'b1; tick(4); busy_clear = 1'b0; tick(6);
    @(negedge clk);
    chk("glitch pre busy", dbusy_a, 0);
    snap();
    tick(1);
    sda = 1'b0; tick(2); sda = 1'b1;
    tick(30);
    @(negedge clk);
    chk("glitch no trigger", c_trig[0] - s_trig[0], 0);
    chk("glitch no activity", (c_end[0] - s_end[0]) + (c_ovr[0] - s_ovr[0]), 0);
    $display("glitch: trigger pulses=%0d", c_trig[0] - s_trig[0]);

    // Reset in the middle of a frame.
    build(8'h77, 8'h88, 64'hCAFE_F00D, 4, 8'h00);
    line_start();
    line_byte(frm[0]); line_byte(frm[1]);
    snap();
    reset = 1'b0;
    tick(1);
    sda = 1'b1; scl = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(10);
    @(negedge clk);
    chk("midreset outputs", {trig_a, dbusy_a, sid_a, ty_a, ser_a, crc_a, idm_a}, 0);
    chk("midreset no end_flag", c_end[0] - s_end[0], 0);
    tick(2);
    snap();
    send_frame();
    tick(20);
    @(negedge clk);
    chk("postreset trigger", c_trig[0] - s_trig[0], 1);
    chk("postreset end_flag", c_end[0] - s_end[0], 1);
    chk("postreset data", {sid_a, ty_a, ser_a}, {8'h77, 8'h88, 32'hCAFE_F00D});
    chk("postreset status", {crc_a, idm_a}, 2'b11);
    $display("post reset frame: id=%h serial=%h crc_status=%0b", sid_a, ser_a, crc_a);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
